// File: rtl/hex_page_ctrl_pkg.sv
// rtl/hex_page_ctrl_pkg.sv - page state encoding and dwell constants for hex_page_ctrl
package hex_page_ctrl_pkg;

    typedef enum logic {
        PAGE_LO = 1'b0,
        PAGE_HI = 1'b1
    } page_e;

    localparam int unsigned DWELL_CYCLES_DEFAULT = 50_000_000;
    localparam int unsigned DWELL_CYCLES_MAX     = 32'd1 << 26;
    localparam int          DWELL_CNT_W          = 26;

endpackage

// File: rtl/hex_page_ctrl_if.sv
// rtl/hex_page_ctrl_if.sv - write/commit/button inputs and visible display outputs
interface hex_page_ctrl_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       page_btn;
    logic [7:0] disp0;
    logic [7:0] disp1;
    logic [7:0] disp2;
    logic [7:0] disp3;
    logic       select;
    logic       page_tick;

    modport master (
        output wr_en, wr_addr, wr_data, commit, page_btn,
        input  disp0, disp1, disp2, disp3, select, page_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, page_btn,
        output disp0, disp1, disp2, disp3, select, page_tick
    );
endinterface

// File: rtl/hex_page_ctrl_btn_edge_sync.sv
// rtl/hex_page_ctrl_btn_edge_sync.sv - two-flop synchronizer plus rising-edge pulse for the page button
module btn_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // High for exactly one cycle per press, however long the button is held.
    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/hex_page_ctrl.sv
// rtl/hex_page_ctrl.sv - shadowed 4-byte hex display with two-page select; HEX_AUTOPAGE_EN adds timed auto-paging
module hex_page_ctrl
    import hex_page_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = DWELL_CYCLES_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    hex_page_ctrl_if.slave bus
);

    if ((DWELL_CYCLES < 2) || (DWELL_CYCLES > DWELL_CYCLES_MAX)) begin : g_bad_dwell
        $error("hex_page_ctrl: DWELL_CYCLES out of range 2..2^26");
    end

    logic [7:0] shadow_q [4];
    logic [7:0] shadow_d [4];
    logic [7:0] disp_q   [4];
    logic [7:0] disp_d   [4];

    // Commit copies the post-write shadow, so a same-cycle write bypasses into the display.
    always_comb begin
        shadow_d = shadow_q;
        if (bus.wr_en) begin
            shadow_d[bus.wr_addr] = bus.wr_data;
        end
        disp_d = disp_q;
        if (bus.commit) begin
            disp_d = shadow_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 8'h00;
                disp_q[i]   <= 8'h00;
            end
        end else begin
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
        end
    end

    assign bus.disp0 = disp_q[0];
    assign bus.disp1 = disp_q[1];
    assign bus.disp2 = disp_q[2];
    assign bus.disp3 = disp_q[3];

    logic btn_pulse;
    logic toggle;

    btn_edge_sync u_btn_edge_sync (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (bus.page_btn),
        .pulse_o (btn_pulse)
    );

`ifdef HEX_AUTOPAGE_EN
    logic [DWELL_CNT_W-1:0] cnt_q;
    logic [DWELL_CNT_W-1:0] cnt_d;
    logic                   expire;

    assign expire = (cnt_q == DWELL_CNT_W'(DWELL_CYCLES - 1));
    // A button edge and an expiry in the same cycle merge into one toggle.
    assign toggle = btn_pulse | expire;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (toggle) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign toggle = btn_pulse;
`endif

    page_e state_q;
    page_e state_d;
    logic  tick_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= PAGE_LO;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= toggle;
        end
    end

    always_comb begin
        state_d = state_q;
        if (toggle) begin
            case (state_q)
                PAGE_LO: state_d = PAGE_HI;
                PAGE_HI: state_d = PAGE_LO;
            endcase
        end
    end

    always_comb begin
        bus.select    = (state_q == PAGE_HI);
        bus.page_tick = tick_q;
    end

endmodule

// File: tb/tb_hex_page_ctrl.sv
// tb/tb_hex_page_ctrl.sv - self-checking bench for hex_page_ctrl, manual or HEX_AUTOPAGE_EN build
module tb_hex_page_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;

    hex_page_ctrl_if bus ();

    hex_page_ctrl #(.DWELL_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

`ifdef HEX_AUTOPAGE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic        commit;
        logic [31:0] exp_disp;
    } wr_vec_t;

    typedef struct {
        logic btn;
        logic exp_sel;
        logic exp_tick;
    } pg_vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    int checks   = 0;
    int failures = 0;
    sb_t     sb_q [$];
    wr_vec_t wv   [$];
    pg_vec_t pv   [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_push(input string name, input logic [31:0] exp);
        sb_q.push_back('{name, exp});
    endtask

    task automatic expect_pop(input logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=%h required=none", act);
        end else begin
            e = sb_q.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    function automatic logic [31:0] disp_word();
        return {bus.disp3, bus.disp2, bus.disp1, bus.disp0};
    endfunction

    function automatic logic [31:0] page_word();
        return {30'd0, bus.page_tick, bus.select};
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic we, input logic [1:0] addr, input logic [7:0] data, input logic cm);
        bus.wr_en   = we;
        bus.wr_addr = addr;
        bus.wr_data = data;
        bus.commit  = cm;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bool_init();
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        bus.page_btn = 1'b0;

        // Page table entry i: button level before edge i+1 after reset release, outputs after it.
`ifdef HEX_AUTOPAGE_EN
        for (int i = 1; i <= 16; i++) begin
            pv.push_back('{(i == 2 || i == 3 || i == 7 || i == 8),
                           ((i >= 4 && i <= 7) || (i >= 9 && i <= 12)),
                           (i == 4 || i == 8 || i == 9 || i == 13)});
        end
`else
        for (int i = 1; i <= 20; i++) begin
            pv.push_back('{(i <= 10 || i == 15 || i == 16),
                           (i >= 3 && i <= 16),
                           (i == 3 || i == 17)});
        end
`endif

        wv.push_back('{1'b1, 2'd0, 8'h12, 1'b0, 32'h0000_0000});
        wv.push_back('{1'b1, 2'd1, 8'h34, 1'b0, 32'h0000_0000});
        wv.push_back('{1'b1, 2'd2, 8'h56, 1'b0, 32'h0000_0000});
        wv.push_back('{1'b1, 2'd3, 8'h78, 1'b0, 32'h0000_0000});
        wv.push_back('{1'b0, 2'd0, 8'h00, 1'b1, 32'h7856_3412});
        wv.push_back('{1'b1, 2'd2, 8'hAA, 1'b0, 32'h7856_3412});
        wv.push_back('{1'b1, 2'd2, 8'h5C, 1'b1, 32'h785C_3412});
        wv.push_back('{1'b0, 2'd2, 8'h00, 1'b1, 32'h785C_3412});
        wv.push_back('{1'b1, 2'd0, 8'hFF, 1'b1, 32'h785C_34FF});
        wv.push_back('{1'b1, 2'd3, 8'h01, 1'b0, 32'h785C_34FF});
        wv.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 32'h785C_34FF});
        wv.push_back('{1'b0, 2'd0, 8'h00, 1'b1, 32'h015C_34FF});

        step();
        step();
        check("reset_disp", disp_word(), 32'h0);
        check("reset_page", page_word(), 32'h0);

        reset = 1'b1;
        for (int i = 0; i < pv.size(); i++) begin
            bus.page_btn = pv[i].btn;
            expect_push($sformatf("page_e%0d", i + 1), {30'd0, pv[i].exp_tick, pv[i].exp_sel});
            step();
            expect_pop(page_word());
        end
        bus.page_btn = 1'b0;

        for (int i = 0; i < wv.size(); i++) begin
            drive(wv[i].we, wv[i].addr, wv[i].data, wv[i].commit);
            expect_push($sformatf("wr_v%0d", i), wv[i].exp_disp);
            step();
            expect_pop(disp_word());
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0);

        // Get to the high page with a nonzero display, then reset mid-cycle.
        bus.page_btn = 1'b1;
        step();
        step();
        bus.page_btn = 1'b0;
        for (int k = 0; k < 12 && bus.select !== 1'b1; k++) begin
            step();
        end
        check("pre_reset_sel", {31'd0, bus.select}, 32'd1);

        drive(1'b1, 2'd0, 8'h77, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_disp", disp_word(), 32'h0);
        check("async_reset_page", page_word(), 32'h0);
        step();
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        step();
        reset = 1'b1;

        for (int i = 1; i <= 4; i++) begin
            expect_push($sformatf("post_reset_e%0d", i),
                        {30'd0, (AUTO && i == 4), (AUTO && i == 4)});
            step();
            expect_pop(page_word());
        end

        drive(1'b0, 2'd0, 8'h00, 1'b1);
        expect_push("post_reset_commit", 32'h0);
        step();
        expect_pop(disp_word());

        drive(1'b1, 2'd1, 8'h9A, 1'b1);
        expect_push("post_reset_bypass", 32'h0000_9A00);
        step();
        expect_pop(disp_word());
        drive(1'b0, 2'd0, 8'h00, 1'b0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic bool_init();
        sb_q.delete();
        wv.delete();
        pv.delete();
    endtask

endmodule

// File: doc/hex_page_ctrl.md
HEX_PAGE_CTRL -- requirements
Module: hex_page_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000000, sets clock cycles per display page in auto mode (range 2..2^26).
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 wr_en  input  1  write strobe; one shadow byte is written per cycle while high.
REQ-005 wr_addr  input  2  shadow byte index 0..3.
REQ-006 wr_data  input  8  byte to write.
REQ-007 commit  input  1  single-cycle pulse that copies shadow bytes to the visible bytes.
REQ-008 page_btn  input  1  asynchronous pushbutton, active-high; each press toggles the page.
REQ-009 disp0..disp3  output  8 each  visible bytes, fed to the downstream 7-segment decoder inputs in0..in3.
REQ-010 select  output  1  page select to the decoder: 0 shows disp0/disp1, 1 shows disp2/disp3.
REQ-011 page_tick  output  1  one-cycle pulse in the cycle select changes.

Function
REQ-012 Shadow bank SHALL hold four 8-bit registers; on wr_en, shadow[wr_addr] SHALL take wr_data at the next edge.
REQ-013 On commit, disp0..disp3 SHALL take the shadow contents at the next edge.
REQ-014 If wr_en and commit are high in the same cycle, the committed value for wr_addr SHALL be wr_data (bypass); the other bytes SHALL take their shadow values.
REQ-015 Visible bytes SHALL change only on commit or reset, never on wr_en alone.
REQ-016 Page FSM SHALL have two states: PAGE_LO (select=0) and PAGE_HI (select=1); each toggle event moves it to the other state.
REQ-017 page_btn SHALL pass through a two-flop synchronizer and a rising-edge detector; a detected edge is a toggle event, 3 cycles after the input rises.
REQ-018 Holding page_btn high SHALL produce exactly one toggle.
REQ-019 Dwell counter SHALL count 0..DWELL_CYCLES-1 and wrap to 0; it SHALL reset to 0 on every toggle event.
REQ-020 page_tick SHALL be high in the same cycle that select takes its new value.
REQ-021 If a button edge and a dwell expiry coincide, the FSM SHALL toggle exactly once and the counter SHALL restart at 0.

Reset
REQ-022 While reset=0: shadow and visible bytes = 8'h00, select=0 (PAGE_LO), page_tick=0, dwell counter=0, synchronizer flops=0.
REQ-023 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge, and SHALL discard any pending write or commit.
REQ-024 After reset deasserts, the first edge SHALL NOT register a button edge unless page_btn is seen rising after the synchronizer clears.

Configuration
REQ-025 Macro HEX_AUTOPAGE_EN defined: a dwell expiry (counter at DWELL_CYCLES-1) SHALL be a toggle event, in addition to button edges.
REQ-026 HEX_AUTOPAGE_EN undefined: the dwell counter SHALL be omitted, only button edges SHALL toggle, and select SHALL otherwise hold.

Structure
REQ-027 The shared package SHALL hold the page state encoding (PAGE_LO=0, PAGE_HI=1) and the default DWELL_CYCLES constant.
REQ-028 The synchronizer and edge detector SHALL be the one sub-module, btn_edge_sync (input async level, output one-cycle pulse).

Verification
REQ-029 Reset, write 8'h12, 8'h34, 8'h56, 8'h78 to addresses 0..3 with no commit -> disp0..3 stay 8'h00; pulse commit -> next edge disp0..3 = 12, 34, 56, 78.
REQ-030 Shadow holds 8'hAA at addr 2, then wr_en to addr 2 with data 8'h5C in the same cycle as commit -> disp2 = 8'h5C and shadow[2] = 8'h5C.
REQ-031 Auto mode with DWELL_CYCLES=4 -> select toggles every 4 cycles and page_tick pulses on each toggle; a button edge on an expiry cycle -> single toggle, counter restarts.
REQ-032 Manual mode: page_btn held high for 10 cycles -> select toggles once, 3 cycles after the input rises; no further toggles without a new press.
REQ-033 Assert reset mid-dwell with select=1 and disp nonzero -> immediately select=0, disp=00, counter=0; release -> normal operation resumes.
